// File: rtl/fib_pkg.sv
// fib_pkg: shared types and default widths for the Fibonacci engine.
//   fib_state_t   : controller states (IDLE, CALC, DONE)
//   FIB_DATA_W_DEF: default result/term width
//   FIB_IDX_W_DEF : default index/counter width
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fib_state_t;

  localparam int unsigned FIB_DATA_W_DEF = 16;
  localparam int unsigned FIB_IDX_W_DEF  = 8;

endpackage

// File: rtl/fib_step.sv
// fib_step: one Fibonacci step, sum = a + b at DATA_W+1 bits.
// Ports:
//   i_a, i_b : previous two terms
//   o_sum    : low DATA_W bits of a + b
//   o_carry  : carry-out; set when the sum does not fit in DATA_W
module fib_step #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/fib_seq_engine.sv
// fib_seq_engine: sequential Fibonacci engine returning F(n_in).
// Optional macro: FIB_STREAM_EN adds the per-term stream (term/term_valid).
// Ports:
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   start      : request pulse, accepted only in IDLE with abort low
//   abort      : cancels an in-flight computation (CALC only)
//   n_in       : requested index, latched on the accept edge
//   dout       : F(n), or all-ones on overflow; held until next completion
//   done       : one-cycle completion strobe
//   busy       : high while not IDLE
//   ovf        : result overflowed DATA_W; held with dout
//   term       : (FIB_STREAM_EN) most recent computed term
//   term_valid : (FIB_STREAM_EN) one-cycle strobe qualifying term
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = FIB_DATA_W_DEF,
  parameter int unsigned IDX_W  = FIB_IDX_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  n_in,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy,
  output logic              ovf
`ifdef FIB_STREAM_EN
  ,
  output logic [DATA_W-1:0] term,
  output logic              term_valid
`endif
);

  fib_state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_a, r_b, r_dout;
  logic [IDX_W-1:0]  r_cnt, r_n;
  logic              r_ovf;
  logic [DATA_W-1:0] w_sum;
  logic              w_carry;
  logic [IDX_W-1:0]  w_cnt_inc;
  logic              w_accept, w_small, w_last;

  fib_step #(.DATA_W(DATA_W)) u_step (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_accept  = start && !abort;
  assign w_small   = (n_in[IDX_W-1:1] == '0);  // n_in <= 1
  assign w_cnt_inc = r_cnt + IDX_W'(1);
  assign w_last    = (w_cnt_inc == r_n);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_small ? DONE : CALC;
      CALC: begin
        if (abort)                  w_state_nxt = IDLE;
        else if (w_carry || w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    done = (r_state == DONE);
    busy = (r_state != IDLE);
  end

  // Datapath: terms, counter, held result
`ifdef FIB_STREAM_EN
  logic [DATA_W-1:0] r_term;
  logic              r_term_valid;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_n    <= '0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
`ifdef FIB_STREAM_EN
      r_term       <= '0;
      r_term_valid <= 1'b0;
`endif
    end else begin
`ifdef FIB_STREAM_EN
      r_term_valid <= 1'b0;
`endif
      case (r_state)
        IDLE: if (w_accept) begin
          r_n <= n_in;
          if (w_small) begin
            r_dout <= {{(DATA_W-1){1'b0}}, n_in[0]};
            r_ovf  <= 1'b0;
`ifdef FIB_STREAM_EN
            r_term       <= {{(DATA_W-1){1'b0}}, n_in[0]};
            r_term_valid <= 1'b1;
`endif
          end else begin
            r_a   <= '0;
            r_b   <= DATA_W'(1);
            r_cnt <= IDX_W'(1);
          end
        end
        CALC: if (!abort) begin
          if (w_carry) begin
            r_dout <= '1;
            r_ovf  <= 1'b1;
          end else begin
            r_a   <= r_b;
            r_b   <= w_sum;
            r_cnt <= w_cnt_inc;
`ifdef FIB_STREAM_EN
            r_term       <= w_sum;
            r_term_valid <= 1'b1;
`endif
            if (w_last) begin
              r_dout <= w_sum;
              r_ovf  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = r_dout;
  assign ovf  = r_ovf;
`ifdef FIB_STREAM_EN
  assign term       = r_term;
  assign term_valid = r_term_valid;
`endif

endmodule

// File: tb/tb_fib_seq_engine.sv
// Self-checking bench for fib_seq_engine (DATA_W=16, IDX_W=8).
module tb_fib_seq_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 8;
  localparam longint      MAXV = (64'd1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n, start, abort;
  logic [IW-1:0] n_in;
  logic [DW-1:0] dout;
  logic          done, busy, ovf;
`ifdef FIB_STREAM_EN
  logic [DW-1:0] term;
  logic          term_valid;
`endif

  int total = 0;
  int bad   = 0;
  longint exp_terms[$];

  always #5 clk = ~clk;

  fib_seq_engine #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .n_in    (n_in),
    .dout    (dout),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf)
`ifdef FIB_STREAM_EN
    ,
    .term       (term),
    .term_valid (term_valid)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: iterate the recurrence with wide arithmetic; stop at the first term
  // that does not fit in DW bits. lat counts edges from the accept edge (inclusive)
  // until done is visible.
  task automatic model(input int n, output longint d, output longint o, output int lat);
    longint f0, f1, f;
    exp_terms.delete();
    if (n <= 1) begin
      d = n; o = 0; lat = 1;
      exp_terms.push_back(n);
      return;
    end
    f0 = 0; f1 = 1; d = 0; o = 0; lat = n;
    for (int k = 2; k <= n; k++) begin
      f = f0 + f1;
      if (f > MAXV) begin
        d = MAXV; o = 1; lat = k;
        return;
      end
      exp_terms.push_back(f);
      f0 = f1; f1 = f;
      d = f;
    end
  endtask

  task automatic run_job(input int n, input int poke_at, input string tag);
    longint ed, eo;
    int     el, lat;
    bit     seen, busy_ok;
    longint got[$];
    model(n, ed, eo, el);
    start = 1'b1; n_in = n[IW-1:0];
    tick;
    start = 1'b0;
    lat = 1; seen = 0; busy_ok = 1;
    while (lat <= 300) begin
      if (busy !== 1'b1) busy_ok = 0;
`ifdef FIB_STREAM_EN
      if (term_valid === 1'b1) got.push_back(term);
`endif
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (lat == poke_at) begin
        start = 1'b1; n_in = 8'd3;
      end
      tick;
      start = 1'b0;
      lat++;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    else begin
      chk({tag, "_lat"},  lat, el);
      chk({tag, "_dout"}, dout, ed);
      chk({tag, "_ovf"},  ovf, eo);
      chk({tag, "_busy"}, busy_ok, 1);
    end
    tick;
    chk({tag, "_done1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
`ifdef FIB_STREAM_EN
    chk({tag, "_tv_end"}, term_valid, 0);
    chk({tag, "_nterms"}, got.size(), exp_terms.size());
    for (int i = 0; i < got.size() && i < exp_terms.size(); i++)
      chk({tag, "_term"}, got[i], exp_terms[i]);
`endif
  endtask

  initial begin
    longint prev_d, prev_o;
    bit     quiet;
    int     rn;

    // Reset state
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; n_in = '0;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf",  ovf, 0);
`ifdef FIB_STREAM_EN
    chk("rst_term", term, 0);
    chk("rst_tv",   term_valid, 0);
`endif
    reset_n = 1'b1;
    tick;

    // Small indices, nominal run with start poked mid-flight, overflow boundary
    run_job(0, 0, "n0");
    run_job(1, 0, "n1");
    run_job(2, 0, "n2");
    run_job(10, 3, "n10");
    chk("n10_val", dout, 16'h0037);
    run_job(24, 0, "n24");
    chk("n24_val", dout, 46368);
    run_job(25, 0, "n25");
    chk("n25_val", dout, 16'hFFFF);
    run_job(30, 0, "n30");
    run_job(6, 0, "n6");

    // Abort at cycle 3 of n=15: back to IDLE, no done, result held
    prev_d = dout; prev_o = ovf;
    start = 1'b1; n_in = 8'd15;
    tick; start = 1'b0;
    tick; tick;
    abort = 1'b1;
    tick; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, prev_d);
    chk("abort_ovf",  ovf, prev_o);
`ifdef FIB_STREAM_EN
    chk("abort_tv", term_valid, 0);
`endif
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    chk("abort_quiet", quiet, 1);

    // start together with abort in IDLE is not accepted
    start = 1'b1; abort = 1'b1; n_in = 8'd5;
    tick; start = 1'b0; abort = 1'b0;
    chk("stab_busy", busy, 0);
    tick;
    chk("stab_done", done, 0);
    chk("stab_dout", dout, prev_d);

    // Async reset mid-CALC (n=20) after a nonzero result
    run_job(10, 0, "pre_rst");
    start = 1'b1; n_in = 8'd20;
    tick; start = 1'b0;
    tick; tick; tick;
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_dout", dout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ovf",  ovf, 0);
    tick;
    #2 reset_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    chk("mrst_quiet", quiet, 1);

    // Randomized jobs with random IDLE gaps (gap 0 = earliest re-accept)
    for (int j = 0; j < 12; j++) begin
      rn = $urandom_range(40, 0);
      run_job(rn, 0, "rand");
      for (int g = $urandom_range(3, 0); g > 0; g--) tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_seq_engine.md
Name: fib_seq_engine

Overview:
Parametrised Fibonacci engine, the successor to the fixed 16-bit FSM. It takes a term index n and returns F(n) with F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- Additions over the previous generation: configurable data/index widths, overflow detection with early termination, an abort input, an explicit busy/done handshake, and an optional per-term stream.
- Sits as a sequential compute leaf under the team's control/test wrapper.

Parameters:
DATA_W, 16, width of result and internal terms
IDX_W, 8, width of requested index n (counter width)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request pulse; accepted only in IDLE
abort  in  1  cancel in-flight computation
n_in  in  IDX_W  requested index, sampled on accept edge
dout  out  DATA_W  result F(n), or all-ones on overflow
done  out  1  one-cycle completion strobe
busy  out  1  high whenever state != IDLE
ovf  out  1  result overflowed DATA_W; valid with done, held with dout
term  out  DATA_W  current term (only with FIB_STREAM_EN)
term_valid  out  1  term strobe (only with FIB_STREAM_EN)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE; dout, done, busy, ovf, term, term_valid = 0. Internal a, b, cnt = 0.
- All outputs are registered or decoded from registered state. No combinational input-to-output paths.
- States (enum from package): IDLE, CALC, DONE.
- IDLE:
  - start=1 and abort=0 accepts the request: latch n_in.
  - n_in<=1: dout<=n_in (zero-extended), ovf<=0, go to DONE.
  - n_in>=2: a<=0, b<=1, cnt<=1, go to CALC.
  - abort in IDLE has no effect; start with abort=1 is ignored.
- CALC, each cycle:
  - sum = a+b computed at DATA_W+1 bits.
  - Carry-out set: dout<=all-ones, ovf<=1, go to DONE immediately.
  - Otherwise: a<=b, b<=sum, cnt<=cnt+1; when cnt+1==n, dout<=sum, ovf<=0, go to DONE.
  - abort=1 overrides everything: go to IDLE, no done, dout/ovf keep their previous values.
  - start is ignored.
- DONE: done=1 for exactly this cycle, then unconditional return to IDLE. start and abort are ignored in DONE.
- Latency: done is high in the cycle after the edge that completes the result.
  - Accept edge to DONE entry is max(n-1,1) edges; overflow shortens this.
  - Back-to-back: the earliest next accept is the cycle after DONE (one IDLE cycle minimum).
- busy = (state==CALC or state==DONE).
- dout/ovf hold their last result until the next completion. They are not cleared on accept.
- n_in changes while busy are ignored; the latched copy is used.
- Reset mid-CALC: immediate return to reset values, no done.
- Width rule: wrap never occurs. Overflow is the only out-of-range outcome.
  - DATA_W=16 gives F(24)=46368 as the largest valid result; n=25 yields ovf.

Optional Feature:
FIB_STREAM_EN
- Defined:
  - term/term_valid ports exist.
  - Each non-overflowing CALC cycle registers term<=sum with term_valid=1 the following cycle.
  - n<=1 emits a single term=n at DONE entry.
  - abort suppresses further strobes.
- Undefined:
  - Ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package fib_pkg: state enum type fib_state_t (IDLE, CALC, DONE), default width constants FIB_DATA_W_DEF=16 and FIB_IDX_W_DEF=8.
- One sub-module, fib_step: parametrised DATA_W adder returning sum and carry-out. Instantiated once in CALC datapath.

Test Plan:
- Reset: reset_n low mid-CALC (n=20) -> all outputs 0 asynchronously, state IDLE, no done after release.
- Small indices: n=0 -> dout=0 and n=1 -> dout=1, each with done one cycle after accept and ovf=0. n=2 -> dout=1, latency 1.
- Nominal run: n=10 -> dout=55 (0x0037), done exactly 9 cycles after accept; busy high throughout, single-cycle done.
- Overflow (DATA_W=16):
  - n=24 -> dout=46368, ovf=0.
  - n=25 -> dout=0xFFFF, ovf=1, done at the edge the carry occurs.
- Handshake: start pulsed while busy is ignored; abort at cycle 3 of n=15 -> IDLE, no done, dout keeps prior value. start+abort together in IDLE -> not accepted.
- FIB_STREAM_EN with n=6 -> term_valid strobes with terms 1, 2, 3, 5, 8, and final dout=8.
